// File: rtl/rt_encoder.sv
// rt_encoder: one-hot register-select word -> 5-bit register number.
//
// Two-stage valid/ready pipeline. S1 captures the raw select word; S2 holds
// the encoded index plus the one-hot violation flags. All outputs come
// straight from S2 flops (out_ibus is only a constant-shift rewiring of the
// S2 index), so there is no combinational path from in_sel to any output.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. A producer holds valid (and data) until it sees ready; ready
// never depends on the same interface's valid.
//
// Ports:
//   clk, reset_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     input handshake, in_sel = one-hot select word
//   out_valid/out_ready   output handshake
//   out_idx               index of the lowest set bit of the accepted word
//   out_ibus              out_idx placed at [FIELD_LSB+4:FIELD_LSB], rest 0
//   out_err_zero          accepted word was all zeros (only while out_valid)
//   out_err_multi         accepted word had >1 bit set (only while out_valid)
//   err_count             saturating violation counter, present only when
//                         the macro SEL_ENC_ERRCNT_EN is defined
module rt_encoder #(
  parameter int unsigned FIELD_LSB = 16,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_ibus,
  output logic        out_err_zero,
  output logic        out_err_multi
`ifdef SEL_ENC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  // Stage 1: raw select word
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_sel_q, s1_sel_d;

  // Stage 2: encode results
  logic        s2_valid_q, s2_valid_d;
  logic [4:0]  s2_idx_q, s2_idx_d;
  logic        s2_err_zero_q, s2_err_zero_d;
  logic        s2_err_multi_q, s2_err_multi_d;

  logic        s1_ready;
  logic        s2_ready;
  logic [4:0]  enc_idx;
  logic [5:0]  enc_cnt;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;

  // Lowest-set-bit index and population count of the S1 word. Scanning from
  // the top down lets the lowest set bit win the last assignment.
  always_comb begin
    enc_idx = '0;
    enc_cnt = '0;
    for (int i = 31; i >= 0; i--) begin
      if (s1_sel_q[i]) enc_idx = 5'(i);
    end
    for (int i = 0; i < 32; i++) begin
      enc_cnt = enc_cnt + 6'(s1_sel_q[i]);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sel_d   = s1_sel_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_sel_d = in_sel;
    end
  end

  // When S2 advances with an S1 bubble the flags drop to 0, so they are
  // never asserted while out_valid is low. The index simply holds.
  always_comb begin
    s2_valid_d     = s2_valid_q;
    s2_idx_d       = s2_idx_q;
    s2_err_zero_d  = s2_err_zero_q;
    s2_err_multi_d = s2_err_multi_q;
    if (s2_ready) begin
      s2_valid_d     = s1_valid_q;
      s2_err_zero_d  = s1_valid_q && (enc_cnt == 6'd0);
      s2_err_multi_d = s1_valid_q && (enc_cnt > 6'd1);
      if (s1_valid_q) s2_idx_d = enc_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q     <= 1'b0;
      s1_sel_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_idx_q       <= '0;
      s2_err_zero_q  <= 1'b0;
      s2_err_multi_q <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_sel_q       <= s1_sel_d;
      s2_valid_q     <= s2_valid_d;
      s2_idx_q       <= s2_idx_d;
      s2_err_zero_q  <= s2_err_zero_d;
      s2_err_multi_q <= s2_err_multi_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_idx       = s2_idx_q;
  assign out_err_zero  = s2_err_zero_q;
  assign out_err_multi = s2_err_multi_q;
  assign out_ibus      = 32'(s2_idx_q) << FIELD_LSB;

`ifdef SEL_ENC_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  // Counts output transfers carrying a violation; sticks at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (s2_valid_q && out_ready && (s2_err_zero_q || s2_err_multi_q) &&
        (err_count_q != '1)) begin
      err_count_d = err_count_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) err_count_q <= '0;
    else          err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  localparam int unsigned unused_errcnt_w = ERRCNT_W;
`endif

endmodule
